// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK receive chain: frame-sync FSM
// state encoding, default sync word and a shift-in helper.
package qpsk_pkg;

    localparam int SYNC_W = 16;
    localparam logic [SYNC_W-1:0] SYNC_WORD_DEFAULT = 16'hEB90;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } fs_state_e;

    function automatic logic [SYNC_W-1:0] shift_in(input logic [SYNC_W-1:0] sr,
                                                   input logic              b);
        return {sr[SYNC_W-2:0], b};
    endfunction

endpackage

// File: rtl/sync_word_det.sv
// Combinational header compare of a 16-bit bit window against the sync word
// and against its bitwise inverse (180 degree carrier ambiguity).
module sync_word_det
    import qpsk_pkg::*;
#(
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic [SYNC_W-1:0] window,
    output logic              match,
    output logic              match_inv
);

    assign match     = (window == SYNC_WORD);
    assign match_inv = (window == ~SYNC_WORD);

endmodule

// File: rtl/frame_sync_s2p.sv
// Frame synchroniser and serial-to-parallel converter: hunts for the sync word,
// then emits PAYLOAD_BYTES bytes. Define FRAME_SYNC_PHASE_AMBIG_EN to also lock on ~SYNC_WORD.
module frame_sync_s2p
    import qpsk_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_i,
    input  logic       bit_vld_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       locked_o,
    output logic       polarity_o
);

    localparam logic [7:0]  LAST_BYTE = 8'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

    fs_state_e   state_q, state_d;
    logic [15:0] hunt_q;
    logic [7:0]  byte_sr_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  byte_cnt_q;
    logic [15:0] wd_q;
    logic        pol_q;

    logic [15:0] hunt_win;
    logic        det_match, det_match_inv, hit_inv;
    logic        payload_bit;
    logic [7:0]  byte_next;
    logic        lock_hit, lock_inv, byte_done, frame_done, timeout;

    assign hunt_win    = shift_in(hunt_q, ser_i);
    assign payload_bit = ser_i ^ pol_q;
    assign byte_next   = {byte_sr_q[6:0], payload_bit};

    sync_word_det #(
        .SYNC_WORD (SYNC_WORD)
    ) u_det (
        .window    (hunt_win),
        .match     (det_match),
        .match_inv (det_match_inv)
    );

`ifdef FRAME_SYNC_PHASE_AMBIG_EN
    assign hit_inv = det_match_inv;
`else
    logic unused_match_inv;
    assign unused_match_inv = det_match_inv;
    assign hit_inv          = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        lock_hit   = 1'b0;
        lock_inv   = 1'b0;
        byte_done  = 1'b0;
        frame_done = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (bit_vld_i && (det_match || hit_inv)) begin
                    state_d  = ST_PAYLOAD;
                    lock_hit = 1'b1;
                    lock_inv = !det_match;  // true match wins over inverted
                end
            end
            ST_PAYLOAD: begin
                if (bit_vld_i) begin
                    if (bit_cnt_q == 3'd7) begin
                        byte_done = 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            frame_done = 1'b1;
                            state_d    = ST_HUNT;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop,
    // including the shift registers, has an async reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hunt_q        <= '0;
            byte_sr_q     <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            wd_q          <= '0;
            byte_o        <= '0;
            byte_vld_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
        end else begin
            byte_vld_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            if (state_q == ST_HUNT) begin
                if (bit_vld_i) begin
                    hunt_q <= hunt_win;
                end
                if (lock_hit) begin
                    frame_start_o <= 1'b1;
                    byte_sr_q     <= '0;
                    bit_cnt_q     <= '0;
                    byte_cnt_q    <= '0;
                    wd_q          <= '0;
                end
            end else if (bit_vld_i) begin
                wd_q      <= '0;
                byte_sr_q <= byte_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (byte_done) begin
                    byte_o     <= byte_next;
                    byte_vld_o <= 1'b1;
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                end
                if (frame_done) begin
                    frame_end_o <= 1'b1;
                    hunt_q      <= '0;
                    byte_sr_q   <= '0;
                    bit_cnt_q   <= '0;
                    byte_cnt_q  <= '0;
                end
            end else if (timeout) begin
                // partial byte is dropped silently
                hunt_q     <= '0;
                byte_sr_q  <= '0;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                wd_q       <= '0;
            end else begin
                wd_q <= wd_q + 16'd1;
            end
        end
    end

`ifdef FRAME_SYNC_PHASE_AMBIG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_q <= 1'b0;
        end else if (lock_hit) begin
            pol_q <= lock_inv;
        end
    end
`else
    assign pol_q = 1'b0;
`endif

    assign locked_o   = (state_q == ST_PAYLOAD);
    assign polarity_o = pol_q;

endmodule

// File: tb/tb_frame_sync_s2p.sv
// Self-checking bench for frame_sync_s2p: expected payload bytes are queued as
// frames are sent and compared whenever the DUT strobes byte_vld_o.
`timescale 1ns/1ps
module tb_frame_sync_s2p;

    localparam logic [15:0] SYNC   = 16'hEB90;
    localparam int          NBYTES = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_i = 1'b0;
    logic       bit_vld_i = 1'b0;
    logic [7:0] byte_o;
    logic       byte_vld_o, frame_start_o, frame_end_o, locked_o, polarity_o;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   fs_cnt = 0, fe_cnt = 0, bv_cnt = 0;
    logic locked_seen = 1'b0;

    always #5 clk = ~clk;

    frame_sync_s2p dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ser_i         (ser_i),
        .bit_vld_i     (bit_vld_i),
        .byte_o        (byte_o),
        .byte_vld_o    (byte_vld_o),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .locked_o      (locked_o),
        .polarity_o    (polarity_o)
    );

    // Output monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (frame_start_o) fs_cnt++;
        if (frame_end_o) fe_cnt++;
        if (locked_o) locked_seen = 1'b1;
        if (byte_vld_o) begin
            bv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected: got byte_o=%h frame_end_o=%b, required no byte", byte_o, frame_end_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({byte_o, frame_end_o} !== {mon_e.data, mon_e.last}) begin
                    errors++;
                    $display("FAIL byte_data: got byte_o=%h frame_end_o=%b, required %h/%b", byte_o, frame_end_o, mon_e.data, mon_e.last);
                end
            end
        end else if (frame_end_o) begin
            checks++;
            errors++;
            $display("FAIL frame_end_alone: frame_end_o=1 without byte_vld_o");
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "bench timeout");
    end

    task automatic apply_reset();
        bit_vld_i = 1'b0;
        ser_i     = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int spacing);
        ser_i     = b;
        bit_vld_i = 1'b1;
        @(negedge clk);
        bit_vld_i = 1'b0;
        repeat (spacing - 1) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] v, input int n, input int spacing);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], spacing);
    endtask

    task automatic push_frame(input logic [8*NBYTES-1:0] f);
        exp_t e;
        for (int k = 0; k < NBYTES; k++) begin
            e.data = f[8*(NBYTES-k)-1 -: 8];
            e.last = (k == NBYTES - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [15:0] hdr, input logic [8*NBYTES-1:0] f, input int spacing);
        send_bits(hdr, 16, spacing);
        for (int k = 0; k < NBYTES; k++) send_bits({8'h00, f[8*(NBYTES-k)-1 -: 8]}, 8, spacing);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({byte_o, byte_vld_o, frame_start_o, frame_end_o, locked_o, polarity_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got byte=%h vld=%b fs=%b fe=%b lock=%b pol=%b, required all 0",
                     byte_o, byte_vld_o, frame_start_o, frame_end_o, locked_o, polarity_o);
        end
    endtask

    task automatic test_basic();
        int fs0 = fs_cnt, fe0 = fe_cnt, bv0 = bv_cnt;
        push_frame(64'h0102030405060708);
        send_bits(SYNC, 16, 100);
        checks++;
        if ({locked_o, polarity_o} !== 2'b10) begin
            errors++;
            $display("FAIL basic_lock: got locked=%b polarity=%b, required 1/0", locked_o, polarity_o);
        end
        for (int k = 1; k <= NBYTES; k++) send_bits(16'(k), 8, 100);
        repeat (3) @(negedge clk);
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_unlock: got locked=%b, required 0", locked_o);
        end
        checks++;
        if ((fs_cnt - fs0) != 1 || (fe_cnt - fe0) != 1 || (bv_cnt - bv0) != NBYTES) begin
            errors++;
            $display("FAIL basic_counts: got fs=%0d fe=%0d bytes=%0d, required 1/1/%0d",
                     fs_cnt - fs0, fe_cnt - fe0, bv_cnt - bv0, NBYTES);
        end
        checks++;
        if (byte_o !== 8'h08) begin
            errors++;
            $display("FAIL basic_hold: got byte_o=%h, required 08", byte_o);
        end
    endtask

    task automatic test_bad_header();
        logic [15:0] win = 16'h0;
        logic        b;
        int          fs0;
        apply_reset();
        fs0 = fs_cnt;
        locked_seen = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            b   = 1'(16'hEB91 >> i);
            win = {win[14:0], b};
            send_bit(b, 1);
        end
        for (int i = 0; i < 64; i++) begin
            b = 1'($urandom_range(0, 1));
            if ({win[14:0], b} == SYNC || {win[14:0], b} == ~SYNC) b = ~b;
            win = {win[14:0], b};
            send_bit(b, 1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ((fs_cnt - fs0) != 0 || locked_seen !== 1'b0) begin
            errors++;
            $display("FAIL bad_header: got fs=%0d locked_seen=%b, required 0/0", fs_cnt - fs0, locked_seen);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   fs0, fe0, bv0;
        apply_reset();
        fs0 = fs_cnt; fe0 = fe_cnt; bv0 = bv_cnt;
        foreach (e.data[i]) e.data[i] = 1'b0;
        e.last = 1'b0;
        e.data = 8'h11; exp_q.push_back(e);
        e.data = 8'h22; exp_q.push_back(e);
        e.data = 8'h33; exp_q.push_back(e);
        send_bits(SYNC, 16, 2);
        send_bits(16'h0011, 8, 2);
        send_bits(16'h0022, 8, 2);
        send_bits(16'h0033, 8, 2);
        // a partial byte is left pending when the bits stop
        send_bits(16'h000B, 4, 2);
        send_bit(1'b1, 1);
        repeat (1023) @(negedge clk);
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got locked=%b after 1023 idle clk, required 1", locked_o);
        end
        @(negedge clk);
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expire: got locked=%b after 1024 idle clk, required 0", locked_o);
        end
        repeat (1100 - 1024) @(negedge clk);
        checks++;
        if ((fe_cnt - fe0) != 0 || (bv_cnt - bv0) != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_partial: got fe=%0d bytes=%0d pending=%0d, required 0/3/0",
                     fe_cnt - fe0, bv_cnt - bv0, exp_q.size());
        end
        push_frame(64'hDEADBEEFCAFE5A3C);
        send_frame(SYNC, 64'hDEADBEEFCAFE5A3C, 2);
        repeat (4) @(negedge clk);
        checks++;
        if ((fs_cnt - fs0) != 2 || (fe_cnt - fe0) != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_recover: got fs=%0d fe=%0d pending=%0d, required 2/1/0",
                     fs_cnt - fs0, fe_cnt - fe0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int fs0 = fs_cnt, fe0 = fe_cnt, bv0 = bv_cnt;
        push_frame(64'h0123456789ABCDEF);
        push_frame(64'hFEDCBA9876543210);
        send_frame(SYNC, 64'h0123456789ABCDEF, 1);
        send_frame(SYNC, 64'hFEDCBA9876543210, 1);
        repeat (4) @(negedge clk);
        checks++;
        if ((fs_cnt - fs0) != 2 || (fe_cnt - fe0) != 2 || (bv_cnt - bv0) != 2 * NBYTES || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: got fs=%0d fe=%0d bytes=%0d pending=%0d, required 2/2/%0d/0",
                     fs_cnt - fs0, fe_cnt - fe0, bv_cnt - bv0, exp_q.size(), 2 * NBYTES);
        end
    endtask

    task automatic test_inverted();
        int fs0 = fs_cnt, bv0 = bv_cnt;
        locked_seen = 1'b0;
`ifdef FRAME_SYNC_PHASE_AMBIG_EN
        push_frame(64'hA5C396695A3C817E);
`endif
        send_bits(~SYNC, 16, 2);
        checks++;
`ifdef FRAME_SYNC_PHASE_AMBIG_EN
        if ({locked_o, polarity_o} !== 2'b11) begin
            errors++;
            $display("FAIL inv_lock: got locked=%b polarity=%b, required 1/1", locked_o, polarity_o);
        end
`else
        if ({locked_o, polarity_o} !== 2'b00) begin
            errors++;
            $display("FAIL inv_nolock: got locked=%b polarity=%b, required 0/0", locked_o, polarity_o);
        end
`endif
        for (int k = 0; k < NBYTES; k++) send_bits({8'h00, ~8'(64'hA5C396695A3C817E >> (8 * (NBYTES - 1 - k)))}, 8, 2);
        repeat (4) @(negedge clk);
        checks++;
`ifdef FRAME_SYNC_PHASE_AMBIG_EN
        if ((fs_cnt - fs0) != 1 || (bv_cnt - bv0) != NBYTES || exp_q.size() != 0) begin
            errors++;
            $display("FAIL inv_frame: got fs=%0d bytes=%0d pending=%0d, required 1/%0d/0",
                     fs_cnt - fs0, bv_cnt - bv0, exp_q.size(), NBYTES);
        end
`else
        if ((fs_cnt - fs0) != 0 || (bv_cnt - bv0) != 0 || locked_seen !== 1'b0) begin
            errors++;
            $display("FAIL inv_frame: got fs=%0d bytes=%0d locked_seen=%b, required 0/0/0",
                     fs_cnt - fs0, bv_cnt - bv0, locked_seen);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int fs0;
        send_bits(SYNC, 16, 2);
        send_bits(16'h000B, 4, 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_o, byte_vld_o, frame_start_o, frame_end_o, locked_o, polarity_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid: got byte=%h vld=%b fs=%b fe=%b lock=%b pol=%b, required all 0",
                     byte_o, byte_vld_o, frame_start_o, frame_end_o, locked_o, polarity_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fs0 = fs_cnt;
        push_frame(64'h8001FF00AA55C33C);
        send_frame(SYNC, 64'h8001FF00AA55C33C, 2);
        repeat (4) @(negedge clk);
        checks++;
        if ((fs_cnt - fs0) != 1 || exp_q.size() != 0 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: got fs=%0d pending=%0d locked=%b, required 1/0/0",
                     fs_cnt - fs0, exp_q.size(), locked_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_timeout();
        test_back_to_back();
        test_inverted();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sync_s2p.md
FRAME_SYNC_S2P -- requirements
Module: frame_sync_s2p

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90, frame header pattern (MSB sent first).
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 8, bytes per frame after header (range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max clk cycles between bits while in PAYLOAD (range 2..65535).
REQ-004 SHALL have clk  input  1  system clock (sample-rate clock); reset rst_n, asynchronous, active-low.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ser_i  input  1  demodulated serial bit from the IQ combiner.
REQ-007 SHALL have bit_vld_i  input  1  one-cycle strobe; ser_i is sampled only when it is high.
REQ-008 SHALL have byte_o  output  8  assembled payload byte, MSB = first received bit.
REQ-009 SHALL have byte_vld_o  output  1  one-cycle strobe qualifying byte_o.
REQ-010 SHALL have frame_start_o  output  1  one-cycle pulse on header match.
REQ-011 SHALL have frame_end_o  output  1  one-cycle pulse coincident with the last byte_vld_o of a frame.
REQ-012 SHALL have locked_o  output  1  high while in PAYLOAD.
REQ-013 SHALL have polarity_o  output  1  1 = frame received inverted (180 deg ambiguity).

Function
REQ-014 SHALL implement two states, HUNT and PAYLOAD; reset state HUNT.
REQ-015 In HUNT, each bit_vld_i SHALL shift ser_i into a 16-bit register at the LSB; bits are ignored when bit_vld_i is low.
REQ-016 In HUNT, when the post-shift register equals SYNC_WORD, the next cycle SHALL assert frame_start_o, enter PAYLOAD, set locked_o, polarity_o=0.
REQ-017 In PAYLOAD, each bit_vld_i SHALL shift (ser_i XOR polarity_o) into an 8-bit byte register and increment a 3-bit bit counter that wraps 7->0.
REQ-018 On the 8th bit, byte_o and byte_vld_o SHALL update one clk after that bit's bit_vld_i; byte_o holds until the next byte.
REQ-019 A byte counter SHALL count completed bytes; at PAYLOAD_BYTES, frame_end_o SHALL pulse with byte_vld_o, state returns to HUNT, and the 16-bit hunt register, bit and byte counters clear.
REQ-020 Header bits SHALL NOT appear on byte_o; the first payload bit is the bit following the last header bit.
REQ-021 In PAYLOAD, a watchdog SHALL count clks since the last bit_vld_i, cleared on every bit_vld_i; on reaching TIMEOUT, the state returns to HUNT with no frame_end_o, no byte_vld_o for a partial byte, and all counters cleared.
REQ-022 Back-to-back frames SHALL be supported: the header of frame N+1 may start on the bit immediately after the last payload bit of frame N.
REQ-023 bit_vld_i on consecutive cycles SHALL be accepted at one bit per clk without loss.

Reset
REQ-024 On rst_n low: state HUNT; byte_o=8'h00; byte_vld_o, frame_start_o, frame_end_o, locked_o, polarity_o=0; all counters and shift registers 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block hunts afresh.

Configuration
REQ-026 With macro FRAME_SYNC_PHASE_AMBIG_EN defined, HUNT SHALL also match ~SYNC_WORD, entering PAYLOAD with polarity_o=1 so payload bits are inverted back; a true match takes priority.
REQ-027 Without FRAME_SYNC_PHASE_AMBIG_EN, only SYNC_WORD matches and polarity_o SHALL be constant 0.

Structure
REQ-028 The state encoding (HUNT, PAYLOAD) and the default sync word constant SHALL reside in the shared package qpsk_pkg.
REQ-029 Header comparison (including the inverted match) SHALL be a sub-module sync_word_det: combinational compare of a 16-bit window producing match and match_inv.

Verification
REQ-030 Send 16'hEB90 then bytes 8'h01..8'h08 at one bit per 100 clk -> one frame_start_o, byte_o 01..08 each with one byte_vld_o, frame_end_o with 08, locked_o low afterwards.
REQ-031 Send 16'hEB91 followed by random bits -> no frame_start_o, locked_o stays 0.
REQ-032 Stop bit_vld_i after 3 payload bytes for 1100 clk -> return to HUNT at 1024 idle clk, no frame_end_o, next clean frame received correctly.
REQ-033 Two frames back-to-back with bit_vld_i high every cycle -> two frame_start_o and 16 byte_vld_o in order, no bit lost.
REQ-034 With FRAME_SYNC_PHASE_AMBIG_EN, send the bitwise-inverted frame (16'h146F, ~8'hA5=8'h5A) -> polarity_o=1, byte_o=8'hA5; without the macro -> no lock.
REQ-035 Assert rst_n low after 4 payload bits -> all outputs 0 immediately; after release the next frame decodes with correct byte alignment.
